// File: rtl/din_debounce_cond_if.sv
`default_nettype none
// ============================================================================
//  Module      : din_debounce_cond_if
//  Description : Signal bundle between the input conditioner and its user.
//                The master side drives the raw pin level and the sample
//                tick; the slave side (the conditioner) returns the
//                debounced level, debug state and edge pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface din_debounce_cond_if;

    logic       raw_in;      // asynchronous raw input (switch/pin)
    logic       en;          // sample tick
    logic       din_clean;   // debounced level
    logic [1:0] db_state;    // current debounce state (debug)
    logic       busy;        // high while a new level is being qualified
    logic       rise_pulse;  // one-cycle pulse on din_clean 0->1
    logic       fall_pulse;  // one-cycle pulse on din_clean 1->0

    // Stimulus / consumer side
    modport master (
        output raw_in,
        output en,
        input  din_clean,
        input  db_state,
        input  busy,
        input  rise_pulse,
        input  fall_pulse
    );

    // Conditioner side
    modport slave (
        input  raw_in,
        input  en,
        output din_clean,
        output db_state,
        output busy,
        output rise_pulse,
        output fall_pulse
    );

endinterface : din_debounce_cond_if
`default_nettype wire

// File: rtl/din_debounce_cond.sv
`default_nettype none
// ============================================================================
//  Module      : din_debounce_cond
//  Description : Input conditioner for the downstream sequence FSM.
//                Synchronises an asynchronous raw input, rejects glitches
//                with a four-state debounce FSM plus counter, and only moves
//                din_clean once the synchronised level has held for
//                DB_CYCLES en-qualified samples.
//  Options     : `define DEBOUNCE_EDGE_EN to build registered rise/fall
//                pulses; without it both pulse outputs are tied low and no
//                edge logic exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module din_debounce_cond #(
    parameter int SYNC_STAGES = 2,  // synchroniser depth, >= 2
    parameter int DB_CYCLES   = 4,  // qualifying samples, 1 .. 2**CNT_W
    parameter int CNT_W       = 8   // debounce counter width
) (
    input  wire logic            clk,
    input  wire logic            rst,   // asynchronous, active low
    din_debounce_cond_if.slave   dif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES < 2) begin : g_chk_sync
            $error("din_debounce_cond: SYNC_STAGES must be >= 2");
        end
        if (DB_CYCLES < 1) begin : g_chk_db_lo
            $error("din_debounce_cond: DB_CYCLES must be >= 1");
        end
        if (longint'(DB_CYCLES) > (longint'(1) << CNT_W)) begin : g_chk_db_hi
            $error("din_debounce_cond: DB_CYCLES must be <= 2**CNT_W");
        end
    endgenerate

    // Terminal count: the sample that reaches it (with en) is the last one
    // needed, so acceptance happens on the DB_CYCLES-th qualifying sample.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DB_CYCLES - 1);

    // Encoding is visible on db_state, so it is fixed explicitly.
    typedef enum logic [1:0] {
        ST_LO      = 2'b00,
        ST_WAIT_HI = 2'b01,
        ST_HI      = 2'b10,
        ST_WAIT_LO = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    // Shift the raw pin through the metastability chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], dif.raw_in};
        end
    end

    // Only the last flop is safe to use in the clk domain.
    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clean;
    logic             w_clean_nxt;

    // State, counter and debounced level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
        end
    end

    // Next-state logic. A return of s to the settled level always wins over
    // an acceptance in the same cycle, so a level that toggles exactly at
    // the terminal count is treated as a glitch. The counter is cleared on
    // every state exit, so it can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;

        case (r_state)
            ST_LO: begin
                // Entering the wait state does not consume an en sample.
                if (w_s) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                end else if (dif.en) begin
                    if (r_cnt == c_last) begin
                        w_state_nxt = ST_HI;
                        w_clean_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_HI: begin
                if (!w_s) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = ST_HI;
                    w_cnt_nxt   = '0;
                end else if (dif.en) begin
                    if (r_cnt == c_last) begin
                        w_state_nxt = ST_LO;
                        w_clean_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_LO;
                w_cnt_nxt   = '0;
                w_clean_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dif.din_clean = r_clean;
    assign dif.db_state  = r_state;
    assign dif.busy      = (r_state == ST_WAIT_HI) | (r_state == ST_WAIT_LO);

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses are registered from the same next-level decision that updates
    // r_clean, so they line up with the first cycle of the new din_clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_clean_nxt & ~r_clean;
            r_fall <= ~w_clean_nxt & r_clean;
        end
    end

    assign dif.rise_pulse = r_rise;
    assign dif.fall_pulse = r_fall;
`else
    assign dif.rise_pulse = 1'b0;
    assign dif.fall_pulse = 1'b0;
`endif

endmodule : din_debounce_cond
`default_nettype wire

// File: tb/tb_din_debounce_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_din_debounce_cond
//  Description : Self-checking bench for din_debounce_cond. Two instances
//                (DB_CYCLES=4 and DB_CYCLES=1) share the same stimulus and
//                are compared every cycle against a level/pending/sample
//                count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_din_debounce_cond;

    localparam int c_sync = 2;
    localparam int c_db[2] = '{4, 1};

    logic clk;
    logic rst;

    din_debounce_cond_if dif4 ();
    din_debounce_cond_if dif1 ();

    din_debounce_cond #(.SYNC_STAGES(c_sync), .DB_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .dif (dif4.slave)
    );

    din_debounce_cond #(.SYNC_STAGES(c_sync), .DB_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .dif (dif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: the synchroniser is a pure delay line; debouncing is
    // "settled level + is a change pending + how many en samples seen".
    bit sdelay[$];
    bit m_clean[2];
    bit m_pend[2];
    int m_n[2];
    bit m_rise[2];
    bit m_fall[2];

    task automatic model_reset();
        sdelay.delete();
        for (int i = 0; i < c_sync; i++) sdelay.push_front(1'b0);
        for (int k = 0; k < 2; k++) begin
            m_clean[k] = 1'b0;
            m_pend[k]  = 1'b0;
            m_n[k]     = 0;
            m_rise[k]  = 1'b0;
            m_fall[k]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit r, input bit e);
        bit s;
        if (!rst) begin
            model_reset();
            return;
        end
        s = sdelay[$];
        void'(sdelay.pop_back());
        sdelay.push_front(r);
        for (int k = 0; k < 2; k++) begin
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (!m_pend[k]) begin
                if (s != m_clean[k]) begin
                    m_pend[k] = 1'b1;
                    m_n[k]    = 0;
                end
            end else if (s == m_clean[k]) begin
                m_pend[k] = 1'b0;
            end else if (e) begin
                m_n[k]++;
                if (m_n[k] == c_db[k]) begin
                    m_clean[k] = s;
                    m_pend[k]  = 1'b0;
                    m_rise[k]  = s;
                    m_fall[k]  = !s;
                end
            end
        end
    endtask

    function automatic logic [5:0] expected(input int k);
        logic rp, fp;
`ifdef DEBOUNCE_EDGE_EN
        rp = m_rise[k];
        fp = m_fall[k];
`else
        rp = 1'b0;
        fp = 1'b0;
`endif
        // {din_clean, db_state, busy, rise, fall}; db_state is {level, pending}
        return {m_clean[k], m_clean[k], m_pend[k], m_pend[k], rp, fp};
    endfunction

    task automatic check_all(input string tag);
        logic [5:0] act4, act1, exp4, exp1;
        act4 = {dif4.din_clean, dif4.db_state, dif4.busy, dif4.rise_pulse, dif4.fall_pulse};
        act1 = {dif1.din_clean, dif1.db_state, dif1.busy, dif1.rise_pulse, dif1.fall_pulse};
        exp4 = expected(0);
        exp1 = expected(1);
        n_vec++;
        assert (act4 === exp4) else begin
            n_err++;
            $error("FAIL %s db4: observed clean/state/busy/rise/fall=%b expected %b", tag, act4, exp4);
        end
        n_vec++;
        assert (act1 === exp1) else begin
            n_err++;
            $error("FAIL %s db1: observed clean/state/busy/rise/fall=%b expected %b", tag, act1, exp1);
        end
    endtask

    task automatic step(input bit r, input bit e, input string tag);
        dif4.raw_in = r;
        dif4.en     = e;
        dif1.raw_in = r;
        dif1.en     = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
        check_all(tag);
    endtask

    bit rnd_raw;
    int lat;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        dif4.raw_in = 1'b0; dif4.en = 1'b0;
        dif1.raw_in = 1'b0; dif1.en = 1'b0;
        model_reset();

        // Reset state, before and across clock edges
        #3;
        check_all("reset_init");
        step(0, 1, "reset_hold");
        step(1, 1, "reset_hold_raw1");
        rst = 1'b1;

        // Let the raw=1 from reset settle, then return to a clean LO
        for (int i = 0; i < 12; i++) step(1, 1, "poweron_raw1");
        for (int i = 0; i < 12; i++) step(0, 1, "back_to_lo");

        // Latency with en held: raw 0->1 held, measured in edges
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, "rise_latency");
            if (lat == 0 && dif4.din_clean === 1'b1) lat = i;
        end
        n_vec++;
        assert (lat === c_sync + 1 + 4) else begin
            n_err++;
            $error("FAIL latency_edges: observed %0d expected %0d", lat, c_sync + 1 + 4);
        end

        // Short low excursion while HI: aborts back to HI, no fall
        for (int i = 0; i < 3; i++) step(0, 1, "hi_dip");
        for (int i = 0; i < 10; i++) step(1, 1, "hi_dip_recover");

        // Full fall, then repeated one-cycle high glitches
        for (int i = 0; i < 12; i++) step(0, 1, "fall");
        for (int g = 0; g < 5; g++) begin
            step(1, 1, "glitch_hi");
            for (int i = 0; i < 3; i++) step(0, 1, "glitch_lo");
        end

        // en one cycle in three, raw held high
        for (int i = 0; i < 24; i++) step(1, (i % 3) == 0, "en_1_in_3");
        for (int i = 0; i < 12; i++) step(0, 1, "fall2");

        // Asynchronous reset in WAIT_HI with cnt=2
        for (int i = 0; i < 5; i++) step(1, 1, "to_wait_hi");
        n_vec++;
        assert (dif4.db_state === 2'b01) else begin
            n_err++;
            $error("FAIL pre_reset_state: observed %b expected %b", dif4.db_state, 2'b01);
        end
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset_mid");
        step(1, 1, "in_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1, 1, "release_raw1");

        // Randomised phase: long holds, glitches, random en
        rnd_raw = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) rnd_raw = ~rnd_raw;
            step(rnd_raw ^ ($urandom_range(0, 9) == 0),
                 (i < 250) ? 1'b1 : ($urandom_range(0, 2) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_din_debounce_cond
`default_nettype wire
